branch_sequencer: RTL and testbench

Multi-cycle instruction sequencer for KGP-RISC. Owns the program counter, fetches instructions over a request/acknowledge port, and hands non-branch instructions to the execute datapath. It holds the architectural Z/O/C/S flags and resolves all control-flow opcodes (3–14) itself, including PC-relative and register targets and call/return linkage. The instruction fetch port, execute unit and register-file `ra` write port all attach to this block.

---
 rtl/branch_sequencer.sv | 142 ++++++++++++++
 tb/tb_branch_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - KGP-RISC multi-cycle sequencer: PC, fetch, flags and control-flow resolution
module branch_sequencer #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic            exec_start,
    input  logic            exec_done,
    input  logic            flag_we,
    input  logic            zflag_in,
    input  logic            oflag_in,
    input  logic            cflag_in,
    input  logic            sflag_in,
    input  logic [31:0]     rs_value,
    output logic            ra_we,
    output logic [31:0]     ra_data,
    output logic            branch_taken,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      flags,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_BRANCH = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic              exec_first;
    logic [5:0]        opcode;
    logic signed [25:0] offset;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   target;
    logic              is_branch;
    logic              is_call;
    logic              taken;
    logic              z_f, o_f, c_f, s_f;

    assign opcode    = ir[31:26];
    assign offset    = ir[25:0];
    assign pc_plus4  = pc + PC_W'(4);
    assign is_branch = (opcode >= 6'd3) && (opcode <= 6'd14);
    assign is_call   = (opcode == 6'd13);
    assign {z_f, o_f, c_f, s_f} = flags;

    // Register-indirect forms (jr, ret) take a 26-bit absolute target from rs.
    assign target = ((opcode == 6'd4) || (opcode == 6'd14))
                  ? PC_W'(rs_value[25:0])
                  : pc_plus4 + PC_W'(offset);

    assign imem_addr = pc;
    assign state     = cur_state;

    always_comb begin
        taken = 1'b0;
        case (opcode)
            6'd3, 6'd4, 6'd13, 6'd14: taken = 1'b1;
            6'd5:  taken = z_f;
            6'd6:  taken = !z_f;
            6'd7:  taken = c_f;
            6'd8:  taken = !c_f;
            6'd9:  taken = s_f;
            6'd10: taken = !s_f;
            6'd11: taken = o_f;
            6'd12: taken = !o_f;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state  <= S_START;
            pc         <= RESET_PC;
            ir         <= '0;
            flags      <= '0;
            ra_data    <= '0;
            exec_first <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            exec_first <= (cur_state == S_DECODE) && (nxt_state == S_EXEC);
            if (cur_state == S_FETCH && imem_ack) begin
                ir <= imem_rdata;
            end
            // Link value is staged on entry to BRANCH so it is stable alongside ra_we.
            if (cur_state == S_DECODE && is_call) begin
                ra_data <= 32'(pc_plus4);
            end
            if (cur_state == S_EXEC && exec_done) begin
                pc <= pc_plus4;
                if (flag_we) begin
                    flags <= {zflag_in, oflag_in, cflag_in, sflag_in};
                end
            end
            if (cur_state == S_BRANCH) begin
                pc <= taken ? target : pc_plus4;
            end
        end
    end

    always_comb begin
        nxt_state    = cur_state;
        imem_req     = 1'b0;
        exec_start   = 1'b0;
        ra_we        = 1'b0;
        branch_taken = 1'b0;
        case (cur_state)
            S_START:  nxt_state = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) nxt_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_branch)             nxt_state = S_BRANCH;
                else if (opcode == 6'd63)  nxt_state = S_HALT;
                else                       nxt_state = S_EXEC;
            end
            S_EXEC: begin
                exec_start = exec_first;
                if (exec_done) nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                nxt_state    = S_FETCH;
                branch_taken = taken;
                ra_we        = is_call;
            end
            S_HALT:   nxt_state = S_HALT;
            default:  nxt_state = S_START;
        endcase
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer
module tb_branch_sequencer;

    localparam logic [2:0] S_START = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_BRANCH = 3'd4, S_HALT = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        exec_start;
    logic        exec_done = 1'b0;
    logic        flag_we = 1'b0;
    logic        zflag_in = 1'b0, oflag_in = 1'b0, cflag_in = 1'b0, sflag_in = 1'b0;
    logic [31:0] rs_value = '0;
    logic        ra_we;
    logic [31:0] ra_data;
    logic        branch_taken;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic [2:0]  state;

    branch_sequencer #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .exec_start(exec_start), .exec_done(exec_done), .flag_we(flag_we),
        .zflag_in(zflag_in), .oflag_in(oflag_in), .cflag_in(cflag_in), .sflag_in(sflag_in),
        .rs_value(rs_value), .ra_we(ra_we), .ra_data(ra_data), .branch_taken(branch_taken),
        .pc(pc), .flags(flags), .state(state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;

    typedef struct {
        logic [31:0] instr;
        int          ack_dly;
        int          done_dly;
        logic        fwe;
        logic [3:0]  fin;
        logic [31:0] rs;
        logic [31:0] exp_pc;
        logic [3:0]  exp_flags;
        logic        exp_taken;
        logic        exp_call;
        logic [31:0] exp_ra;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(S_START));
        check("rst_pc", pc, 32'h0);
        check("rst_ir_flags_ra", {ir[27:0], flags}, 32'h0);
        check("rst_ra_data", ra_data, 32'h0);
        check("rst_outs", 32'({imem_req, exec_start, ra_we, branch_taken}), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("start_state", 32'(state), 32'(S_START));
        @(negedge clk);
        check("fetch_state", 32'(state), 32'(S_FETCH));
        check("fetch_addr", imem_addr, 32'h0);
        check("fetch_req", 32'(imem_req), 32'h1);
        m_pc = 32'h0;
        m_flags = 4'h0;
    endtask

    // Runs one instruction from its first FETCH cycle until the next FETCH (or HALT).
    task automatic do_instr(input string tag, input vec_t v);
        logic [5:0]  op;
        bit          is_br, is_halt, left, done;
        int          fc, ec, cyc, bt, rw, es, early, req_bad, exp_cyc;
        logic [31:0] ra_seen;
        op = v.instr[31:26];
        is_br = (op >= 3) && (op <= 14);
        is_halt = (op == 63);
        fc = 0; ec = 0; cyc = 0; bt = 0; rw = 0; es = 0; early = 0; req_bad = 0;
        left = 0; done = 0; ra_seen = '0;
        check({tag, "_start_addr"}, imem_addr, m_pc);
        rs_value = v.rs;
        flag_we = v.fwe;
        {zflag_in, oflag_in, cflag_in, sflag_in} = v.fin;
        for (int g = 0; g < 100; g++) begin
            if (left && (state == S_FETCH || state == S_HALT)) begin
                done = 1;
                break;
            end
            if (state != S_FETCH) left = 1;
            if (state == S_FETCH) fc++;
            if (state == S_EXEC) ec++;
            if (state == S_FETCH) begin
                imem_ack = (fc > v.ack_dly);
                imem_rdata = v.instr;
            end else begin
                imem_ack = 1'($urandom);
                imem_rdata = $urandom;
            end
            exec_done = (state == S_EXEC) ? (ec > v.done_dly) : 1'($urandom);
            if (branch_taken) bt++;
            if (ra_we) begin
                rw++;
                ra_seen = ra_data;
            end
            if (exec_start) es++;
            if (imem_req != (state == S_FETCH)) req_bad++;
            if (pc != m_pc) early++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        imem_ack = 1'b0;
        exec_done = 1'b0;
        exp_cyc = is_halt ? 2 + v.ack_dly : (is_br ? 3 + v.ack_dly : 3 + v.ack_dly + v.done_dly);
        check({tag, "_timeout"}, 32'(done), 32'h1);
        check({tag, "_state"}, 32'(state), is_halt ? 32'(S_HALT) : 32'(S_FETCH));
        check({tag, "_pc"}, pc, v.exp_pc);
        check({tag, "_flags"}, 32'(flags), 32'(v.exp_flags));
        check({tag, "_taken"}, bt, 32'(v.exp_taken));
        check({tag, "_ra_we"}, rw, 32'(v.exp_call));
        if (v.exp_call) check({tag, "_ra_data"}, ra_seen, v.exp_ra);
        check({tag, "_exec_start"}, es, (is_br || is_halt) ? 32'h0 : 32'h1);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_pc_early"}, early, 32'h0);
        check({tag, "_req_bad"}, req_bad, 32'h0);
        m_pc = v.exp_pc;
        m_flags = v.exp_flags;
    endtask

    // Reference behaviour derived from the instruction-set rules.
    task automatic model(inout vec_t v);
        int          op;
        int          off;
        logic [31:0] seq;
        bit          pair_flag[4];
        bit          f;
        op = int'(v.instr[31:26]);
        off = int'(v.instr[25:0]);
        if (off >= (1 << 25)) off = off - (1 << 26);
        seq = m_pc + 32'd4;
        pair_flag = '{m_flags[3], m_flags[1], m_flags[0], m_flags[2]};
        v.exp_flags = m_flags;
        v.exp_taken = 0;
        v.exp_call = (op == 13);
        v.exp_ra = seq;
        if (op == 3 || op == 13) begin
            v.exp_taken = 1;
            v.exp_pc = seq + 32'(off);
        end else if (op == 4 || op == 14) begin
            v.exp_taken = 1;
            v.exp_pc = v.rs % 32'h0400_0000;
        end else if (op >= 5 && op <= 12) begin
            f = pair_flag[(op - 5) / 2];
            v.exp_taken = ((op - 5) % 2 == 0) ? f : !f;
            v.exp_pc = v.exp_taken ? seq + 32'(off) : seq;
        end else begin
            v.exp_pc = seq;
            if (v.fwe) v.exp_flags = v.fin;
        end
    endtask

    initial begin
        vec_t rv;
        tbl.push_back('{32'h1400_0010, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0004, 4'h0, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h0FFF_FFF8, 1, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h0000_0000, 2, 1, 1'b1, 4'h8, 32'h0,         32'h0000_0004, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h17FF_FFF8, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0000, 4'h8, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h0FFF_FFF8, 0, 0, 1'b0, 4'h0, 32'h0,         32'hFFFF_FFFC, 4'h8, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h0000_1234, 0, 2, 1'b0, 4'hF, 32'h0,         32'h0000_0000, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h0C00_00FC, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0100, 4'h8, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h3400_0020, 1, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0124, 4'h8, 1'b1, 1'b1, 32'h104});
        tbl.push_back('{32'h3800_0000, 0, 0, 1'b0, 4'h0, 32'hFC00_0104, 32'h0000_0104, 4'h8, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h0400_0000, 0, 0, 1'b0, 4'hF, 32'h0,         32'h0000_0108, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h1C00_0040, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_010C, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h1800_0008, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0110, 4'h8, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h0800_0000, 0, 3, 1'b1, 4'h6, 32'h0,         32'h0000_0114, 4'h6, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h2000_0004, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_0118, 4'h6, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h2C00_0010, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0000_012C, 4'h6, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h1000_0000, 0, 0, 1'b0, 4'h0, 32'h03FF_FFFC, 32'h03FF_FFFC, 4'h6, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h3000_0000, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0400_0000, 4'h6, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h2400_0000, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0400_0004, 4'h6, 1'b0, 1'b0, 32'h0});
        tbl.push_back('{32'h2BFF_FFFC, 0, 0, 1'b0, 4'h0, 32'h0,         32'h0400_0004, 4'h6, 1'b1, 1'b0, 32'h0});
        tbl.push_back('{32'h3400_0000, 2, 0, 1'b0, 4'h0, 32'h0,         32'h0400_0008, 4'h6, 1'b1, 1'b1, 32'h0400_0008});

        apply_reset();
        foreach (tbl[i]) do_instr($sformatf("tbl%0d", i), tbl[i]);

        // Fetch stall, then reset dropped in the middle of EXEC.
        imem_rdata = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            check("stall_req", 32'(imem_req), 32'h1);
            @(posedge clk);
            @(negedge clk);
        end
        check("stall_state", 32'(state), 32'(S_FETCH));
        imem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check("abort_decode", 32'(state), 32'(S_DECODE));
        @(posedge clk);
        @(negedge clk);
        check("abort_exec_start", 32'({state, exec_start}), 32'({S_EXEC, 1'b1}));
        @(posedge clk);
        @(negedge clk);
        check("abort_exec_wait", 32'({state, exec_start}), 32'({S_EXEC, 1'b0}));
        #2 rst = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'(S_START));
        check("abort_pc_flags", {pc[27:0], flags}, 32'h0);
        check("abort_outs", 32'({imem_req, exec_start, ra_we, branch_taken}), 32'h0);
        exec_done = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("stale_done_state", 32'(state), 32'(S_FETCH));
        check("stale_done_pc", pc, 32'h0);
        check("stale_done_flags", 32'(flags), 32'h0);
        exec_done = 1'b0;
        m_pc = 32'h0;
        m_flags = 4'h0;

        // Halt holds with all outputs idle regardless of stray handshakes.
        rv = '{32'hFC00_0000, 1, 0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
        do_instr("halt", rv);
        imem_ack = 1'b1;
        exec_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("halt_hold", 32'({state, imem_req, exec_start, ra_we, branch_taken}), 32'({S_HALT, 4'h0}));
        end
        check("halt_pc", pc, 32'h0);
        apply_reset();

        for (int i = 0; i < 150; i++) begin
            rv.instr = $urandom;
            if ($urandom_range(0, 1) == 1) rv.instr[31:26] = 6'($urandom_range(3, 14));
            else rv.instr[31:26] = 6'($urandom_range(0, 62));
            rv.ack_dly = $urandom_range(0, 3);
            rv.done_dly = $urandom_range(0, 3);
            rv.fwe = 1'($urandom);
            rv.fin = 4'($urandom);
            rv.rs = $urandom;
            model(rv);
            do_instr($sformatf("rnd%0d", i), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
